// File: rtl/temp_data_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// temp_data_ctrl_pkg
//   Shared definitions for the temperature reporter:
//     - ASCII byte constants used to build the report frame
//     - state_t : reporter FSM states (IDLE, CONV, SEND)
//     - FRAME_LEN : bytes per frame; 13 when DATA_CTRL_UNIT_EN is defined
//       (trailing 'C' unit byte sent), 12 otherwise
//     - digit_ascii() : BCD digit to ASCII character
// -----------------------------------------------------------------------------
package temp_data_ctrl_pkg;

   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_DOT   = 8'h2E;
   localparam logic [7:0] ASCII_C     = 8'h43;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      SEND
   } state_t;

`ifdef DATA_CTRL_UNIT_EN
   localparam int unsigned FRAME_LEN = 13;
`else
   localparam int unsigned FRAME_LEN = 12;
`endif

   function automatic logic [7:0] digit_ascii(input logic [3:0] d);
      return ASCII_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/temp_data_ctrl_uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
//   8N1 UART transmitter, LSB first, BAUD_DIV = CLK_FREQ/BAUD clocks per bit.
//   Ports:
//     clk      : system clock
//     rst_n    : synchronous active-low reset (tx forced high)
//     tx_data  : byte to send, captured with tx_start
//     tx_start : 1-cycle request, accepted only while tx_idle = 1
//     tx       : serial line, idle high
//     tx_idle  : transmitter ready for a new byte
//     tx_done  : 1-cycle pulse at the end of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte
   import temp_data_ctrl_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx,
   output logic       tx_idle,
   output logic       tx_done
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BIT_END = BW'(BAUD_DIV - 1);

   logic          r_busy;
   logic [BW-1:0] r_baud;
   logic [3:0]    r_bit;    // 0 = start, 1..8 = data, 9 = stop
   logic [8:0]    r_shift;  // remaining data bits with the stop bit behind them
   logic          r_tx;
   logic          r_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy  <= 1'b0;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '1;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (!r_busy) begin
            if (tx_start) begin
               r_busy  <= 1'b1;
               r_baud  <= '0;
               r_bit   <= '0;
               r_shift <= {1'b1, tx_data};
               r_tx    <= 1'b0;
            end
         end else if (r_baud == BIT_END) begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_bit   <= r_bit + 4'd1;
               r_tx    <= r_shift[0];
               r_shift <= {1'b1, r_shift[8:1]};
            end
         end else begin
            r_baud <= r_baud + BW'(1);
         end
      end
   end

   assign tx      = r_tx;
   assign tx_idle = ~r_busy;
   assign tx_done = r_done;

endmodule

// File: rtl/temp_data_ctrl.sv
// -----------------------------------------------------------------------------
// temp_data_ctrl
//   Periodic temperature reporter. Every TIME_1s+1 clocks it latches
//   temp_data, converts the 24-bit magnitude to 8 BCD digits by sequential
//   double-dabble and sends "+dddd.dddd[C]\r\n" over an 8N1 UART.
//   Build option: DATA_CTRL_UNIT_EN adds the 'C' unit byte (13-byte frame).
//   Ports:
//     clk       : system clock
//     rst_n     : synchronous active-low reset
//     temp_data : [24] sign (1 = negative), [23:0] magnitude in 0.0001 degC
//     tx        : UART serial output, idle high
// -----------------------------------------------------------------------------
module temp_data_ctrl
   import temp_data_ctrl_pkg::*;
#(
   parameter int TIME_1s  = 49_999_999,
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115_200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [24:0] temp_data,
   output logic        tx
);

   localparam int TW = (TIME_1s > 0) ? $clog2(TIME_1s + 1) : 1;
   localparam logic [TW-1:0] T_END   = TW'(TIME_1s);
   localparam logic [3:0]    IDX_END = 4'(FRAME_LEN - 1);

   logic [TW-1:0] r_timer;
   logic          w_tick;

   state_t        r_state;
   logic          r_sign;
   logic [23:0]   r_bin;
   logic [31:0]   r_bcd;
   logic [4:0]    r_iter;
   logic [3:0]    r_idx;
   logic          r_wait;
   logic          r_tx_start;
   logic [7:0]    r_tx_byte;

   logic [31:0]   w_bcd_adj;
   logic [7:0]    w_cur_byte;
   logic [7:0]    w_next_byte;
   logic          w_tx_idle;
   logic          w_tx_done;

   function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic sign,
                                             input logic [31:0] bcd);
      case (idx)
         4'd0:    return sign ? ASCII_MINUS : ASCII_PLUS;
         4'd1:    return digit_ascii(bcd[31:28]);
         4'd2:    return digit_ascii(bcd[27:24]);
         4'd3:    return digit_ascii(bcd[23:20]);
         4'd4:    return digit_ascii(bcd[19:16]);
         4'd5:    return ASCII_DOT;
         4'd6:    return digit_ascii(bcd[15:12]);
         4'd7:    return digit_ascii(bcd[11:8]);
         4'd8:    return digit_ascii(bcd[7:4]);
         4'd9:    return digit_ascii(bcd[3:0]);
`ifdef DATA_CTRL_UNIT_EN
         4'd10:   return ASCII_C;
         4'd11:   return ASCII_CR;
`else
         4'd10:   return ASCII_CR;
`endif
         default: return ASCII_LF;
      endcase
   endfunction

   assign w_tick = (r_timer == T_END);

   always_ff @(posedge clk) begin
      if (!rst_n)      r_timer <= '0;
      else if (w_tick) r_timer <= '0;
      else             r_timer <= r_timer + TW'(1);
   end

   // Double-dabble pre-shift correction: any digit >= 5 gets +3.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int unsigned i = 0; i < 8; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   assign w_cur_byte  = frame_byte(r_idx, r_sign, r_bcd);
   assign w_next_byte = frame_byte(r_idx + 4'd1, r_sign, r_bcd);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_sign     <= 1'b0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_iter     <= '0;
         r_idx      <= '0;
         r_wait     <= 1'b0;
         r_tx_start <= 1'b0;
         r_tx_byte  <= '0;
      end else begin
         r_tx_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_tick) begin
                  r_sign  <= temp_data[24];
                  r_bin   <= temp_data[23:0];
                  r_bcd   <= '0;
                  r_iter  <= '0;
                  r_state <= CONV;
               end
            end
            CONV: begin
               r_bcd  <= (w_bcd_adj << 1) | {31'd0, r_bin[23]};
               r_bin  <= {r_bin[22:0], 1'b0};
               r_iter <= r_iter + 5'd1;
               if (r_iter == 5'd23) begin
                  r_state <= SEND;
                  r_idx   <= '0;
                  r_wait  <= 1'b0;
               end
            end
            SEND: begin
               if (!r_wait) begin
                  if (w_tx_idle) begin
                     r_tx_start <= 1'b1;
                     r_tx_byte  <= w_cur_byte;
                     r_wait     <= 1'b1;
                  end
               end else if (w_tx_done) begin
                  // Next byte is launched straight from tx_done to keep the gap short.
                  if (r_idx == IDX_END) begin
                     r_state <= IDLE;
                     r_idx   <= '0;
                     r_wait  <= 1'b0;
                  end else begin
                     r_idx      <= r_idx + 4'd1;
                     r_tx_start <= 1'b1;
                     r_tx_byte  <= w_next_byte;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_uart (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (r_tx_byte),
      .tx_start (r_tx_start),
      .tx       (tx),
      .tx_idle  (w_tx_idle),
      .tx_done  (w_tx_done)
   );

endmodule

// File: tb/tb_temp_data_ctrl.sv
// -----------------------------------------------------------------------------
// tb_temp_data_ctrl
//   Directed bench for temp_data_ctrl with a shortened report period and a
//   16-clock bit time. Frames are decoded from the tx pin and compared to
//   hand-written ASCII strings. Honors DATA_CTRL_UNIT_EN like the design.
// -----------------------------------------------------------------------------
module tb_temp_data_ctrl;

   localparam int T1  = 2999;
   localparam int CF  = 1_600_000;
   localparam int BD  = 100_000;
   localparam int DIV = CF / BD;
`ifdef DATA_CTRL_UNIT_EN
   localparam int FL = 13;
`else
   localparam int FL = 12;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [24:0] temp_data = '0;
   logic        tx;

   logic [63:0] cyc = '0;
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;
   logic [7:0]  got [16];
   logic [63:0] t_first;
   logic [63:0] t_starts [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 64'd1;

   temp_data_ctrl #(
      .TIME_1s  (T1),
      .CLK_FREQ (CF),
      .BAUD     (BD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .temp_data (temp_data),
      .tx        (tx)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge; samples each bit near its middle.
   task automatic rx_byte(input int tmo, output logic [9:0] bits, output int run,
                          output logic [63:0] ts, output logic ok);
      int   w = 0;
      logic in_run = 1'b1;
      bits = 'x; run = 0; ts = '0; ok = 1'b0;
      while (tx !== 1'b0 && w < tmo) begin
         @(negedge clk);
         w++;
      end
      if (tx !== 1'b0) return;
      ok = 1'b1;
      ts = cyc;
      for (int k = 0; k <= 9*DIV + DIV/2; k++) begin
         if (k > 0) @(negedge clk);
         if (in_run && tx === 1'b0) run++;
         else in_run = 1'b0;
         if (k % DIV == DIV/2) bits[k/DIV] = tx;
      end
   endtask

   task automatic rx_frame(input string tag, input int nb, input int tmo,
                           input int chg_idx, input logic [24:0] chg_val);
      logic [9:0]  bits;
      int          run;
      logic [63:0] ts;
      logic        ok;
      for (int i = 0; i < 16; i++) got[i] = 'x;
      for (int i = 0; i < nb; i++) begin
         rx_byte((i == 0) ? tmo : 4*DIV, bits, run, ts, ok);
         chk($sformatf("%s_b%0d_rx", tag, i), ok, 1'b1);
         if (!ok) return;
         got[i]      = bits[8:1];
         t_starts[i] = ts;
         chk($sformatf("%s_b%0d_framing", tag, i), {bits[9], bits[0]}, 2'b10);
         if (i == 0) begin
            t_first = ts;
            chk($sformatf("%s_start_width", tag), run, DIV);
         end else begin
            chk($sformatf("%s_b%0d_gap", tag, i),
                (ts - t_starts[i-1] >= 10*DIV) && (ts - t_starts[i-1] <= 10*DIV + 2), 1'b1);
         end
         if (i == chg_idx) temp_data = chg_val;
      end
   endtask

   task automatic check_body(input string tag, input string body);
      int lows = 0;
      for (int i = 0; i < body.len(); i++)
         chk($sformatf("%s_byte%0d", tag, i), got[i], body[i]);
`ifdef DATA_CTRL_UNIT_EN
      chk($sformatf("%s_unit", tag), got[10], 8'h43);
`endif
      chk($sformatf("%s_cr", tag), got[FL-2], 8'h0D);
      chk($sformatf("%s_lf", tag), got[FL-1], 8'h0A);
      repeat (4*DIV) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk($sformatf("%s_idle_after", tag), lows, 0);
   endtask

   initial begin
      logic [63:0] t_rel;
      logic [63:0] prev;
      int          w;
      int          lows;

      temp_data = 25'd274527;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("reset_tx", tx, 1'b1);
      rst_n = 1'b1;
      t_rel = cyc;

      rx_frame("f1", FL, T1 + 100, -1, '0);
      chk("f1_latency", (t_first - t_rel >= T1 + 2) && (t_first - t_rel <= T1 + 33), 1'b1);
      check_body("f1", "+0027.4527");

      temp_data = {1'b1, 24'd105000};
      prev = t_first;
      rx_frame("f2", FL, T1 + 100, -1, '0);
      chk("f2_period", t_first - prev, T1 + 1);
      check_body("f2", "-0010.5000");

      temp_data = 25'h0FFFFFF;
      prev = t_first;
      rx_frame("f3", FL, T1 + 100, -1, '0);
      chk("f3_period", t_first - prev, T1 + 1);
      check_body("f3", "+1677.7215");

      temp_data = 25'd0;
      rx_frame("f4", FL, T1 + 100, -1, '0);
      check_body("f4", "+0000.0000");

      temp_data = {1'b1, 24'd0};
      rx_frame("f5", FL, T1 + 100, -1, '0);
      check_body("f5", "-0000.0000");

      temp_data = 25'd274527;
      rx_frame("f6", FL, T1 + 100, 2, 25'd294527);
      check_body("f6", "+0027.4527");

      rx_frame("f7", FL, T1 + 100, -1, '0);
      check_body("f7", "+0029.4527");

      // Reset pulse in the middle of byte 5.
      rx_frame("f8", 5, T1 + 100, -1, '0);
      for (int i = 0; i < 5; i++) begin
         string s;
         s = "+0029";
         chk($sformatf("f8_byte%0d", i), got[i], s[i]);
      end
      w = 0;
      while (tx !== 1'b0 && w < 4*DIV) begin
         @(negedge clk);
         w++;
      end
      chk("f8_b5_started", tx, 1'b0);
      repeat (DIV/2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_tx", tx, 1'b1);
      rst_n = 1'b1;
      t_rel = cyc;
      lows = 0;
      repeat (12*DIV) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("rst_tx_held_high", lows, 0);

      rx_frame("f9", FL, T1 + 100, -1, '0);
      chk("f9_latency", (t_first - t_rel >= T1 + 2) && (t_first - t_rel <= T1 + 33), 1'b1);
      check_body("f9", "+0029.4527");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
